ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to a keyboard or mouse, for example 0xED (set LEDs) or 0xFF (reset).
- Counterpart to the existing PS/2 receive path. Shares the same open-collector ps2_clk/ps2_data pins; pad logic drives a pin low when the matching drive_low output is 1, otherwise the pin floats high.
- Runs the full request-to-send sequence, shifts out data/parity/stop on device-generated clock edges, checks the device ACK, and reports completion or error.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK completion (15 ms at 50 MHz).
- CNT_W, 20, width of the shared cycle counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send, LSB first.
- tx_valid  in  1  request. Accepted on a cycle where tx_valid and tx_ready are both 1.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  asynchronous pin value of ps2_clk.
- ps2_data_in  in  1  asynchronous pin value of ps2_data.
- ps2_clk_drive_low  out  1  1 pulls ps2_clk low.
- ps2_data_drive_low  out  1  1 pulls ps2_data low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of a transfer; ack_ok is valid in the same cycle.
- ack_ok  out  1  1 = device ACKed (data sampled low at the 11th falling edge). Holds its value until the next done.
- error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state IDLE; tx_ready=1; busy, done, error, ack_ok, both drive_low outputs = 0; counters cleared. Reset mid-transfer releases both lines on the next cycle; no done or error pulse is emitted.
- Input sync: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
- Falling edge (fe): fe=1 when the previous synced ps2_clk was 1 and the current one is 0. Pin-to-fe latency is 3 clk cycles.
- Accept: on accept, latch tx_data into a shift register and compute parity = ~^tx_data (odd parity). Enter INHIBIT.
- INHIBIT: ps2_clk_drive_low=1 for INHIBIT_CYCLES cycles, then enter REQ.
- REQ (1 cycle): ps2_clk_drive_low=1, ps2_data_drive_low=1 (start bit). Enter XFER; timeout counter starts at 0.
- XFER: ps2_clk_drive_low=0. Bit counter n runs 0..10, advanced on each fe.
  - fe 1-8: ps2_data_drive_low = ~tx_data[n-1], applied the cycle after fe.
  - fe 9: ps2_data_drive_low = ~parity.
  - fe 10: ps2_data_drive_low=0 (stop bit, line released).
  - fe 11: sample synced ps2_data; ack_ok <= (synced data==0). Enter WAIT_IDLE.
- WAIT_IDLE: wait until synced clk and synced data are both 1. Then pulse done, go to IDLE; tx_ready=1 the following cycle.
- Timeout: in XFER or WAIT_IDLE, if the timeout counter reaches TIMEOUT_CYCLES, release both lines, pulse error (no done), ack_ok=0, go to IDLE.
- tx_valid while busy is ignored; no queueing.
- fe during IDLE, INHIBIT or REQ is ignored.

Optional Feature:
- Macro: PS2_TX_GLITCH_FILTER_EN.
- When defined: the synced ps2_clk passes through a 4-sample majority-free filter. The filtered value changes only after 4 consecutive identical samples. Adds 3 cycles to pin-to-fe latency.
- When undefined: fe is derived directly from the 2-flop synchronizer output.
- Protocol behaviour is otherwise identical.

Test Plan:
- Send 0xED. Bench model holds the clock high until ps2_clk_drive_low is released, then generates 11 clock periods of 20 clk (high and low each) and pulls data low at fe 11.
  - ps2_clk_drive_low is high for exactly 5000 cycles, then 1 REQ cycle.
  - Data sampled at rising edges = 1,0,1,1,0,1,1,1; parity=1; stop=1.
  - done=1 with ack_ok=1; error never asserted.
- Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with done and ack_ok=1.
- Device never clocks after REQ -> error pulses exactly TIMEOUT_CYCLES cycles after entering XFER; both lines released; tx_ready=1; done never asserted.
- Device leaves data high at fe 11 -> done=1 with ack_ok=0.
- tx_valid held high with 0x55 during a 0xED transfer -> only 0xED is transmitted. After done, 0x55 is accepted on the first tx_ready cycle.
- rst asserted at fe 4 -> next cycle both drive_low=0, busy=0, no done or error. A subsequent 0xF4 transmits correctly.
- With PS2_TX_GLITCH_FILTER_EN: a 2-cycle low glitch on ps2_clk does not advance the bit counter.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shift on device clock, ACK check, timeout.
// Optional macro PS2_TX_GLITCH_FILTER_EN adds a 4-sample stability filter on the synced ps2_clk.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, WAIT_IDLE} state_t;
  state_t state, state_nx;

  logic             clk_s1, clk_s2, data_s1, data_s2;
  logic             clk_cur, clk_q, fe, tmo;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nbit;
  logic [8:0]       sh;
  logic             data_low, ack_q;

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] hist;
  logic       clk_hold;

  always_comb begin
    clk_cur = clk_hold;
    if (&{hist, clk_s2})       clk_cur = 1'b1;
    else if (~|{hist, clk_s2}) clk_cur = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist     <= 3'b111;
      clk_hold <= 1'b1;
    end else begin
      hist     <= {hist[1:0], clk_s2};
      clk_hold <= clk_cur;
    end
  end
`else
  assign clk_cur = clk_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_q <= 1'b1;
    else     clk_q <= clk_cur;
  end

  assign fe  = clk_q & ~clk_cur;
  assign tmo = ((state == XFER) || (state == WAIT_IDLE)) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      IDLE:      if (tx_valid) state_nx = INHIBIT;
      INHIBIT:   if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_nx = REQ;
      REQ:       state_nx = XFER;
      XFER: begin
        if (tmo) begin
          error    = 1'b1;
          state_nx = IDLE;
        end else if (fe && nbit == 4'd10) begin
          state_nx = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tmo) begin
          error    = 1'b1;
          state_nx = IDLE;
        end else if (clk_cur && data_s2) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      nbit     <= '0;
      sh       <= '0;
      data_low <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          cnt      <= '0;
          nbit     <= '0;
          data_low <= 1'b0;
          if (tx_valid) sh <= {~^tx_data, tx_data};
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (state_nx == REQ) begin
            cnt      <= '0;
            data_low <= 1'b1;
          end
        end
        REQ: cnt <= '0;
        XFER, WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            data_low <= 1'b0;
            ack_q    <= 1'b0;
          end else if (state == XFER && fe) begin
            // fe 1..9 put data then parity on the line; fe 10 releases it; fe 11 samples ACK.
            nbit <= nbit + 1'b1;
            if (nbit < 4'd9) begin
              data_low <= ~sh[0];
              sh       <= {1'b0, sh[8:1]};
            end else if (nbit == 4'd9) begin
              data_low <= 1'b0;
            end else begin
              ack_q <= ~data_s2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_ready           = (state == IDLE);
  assign busy               = (state != IDLE);
  assign ps2_clk_drive_low  = (state == INHIBIT) || (state == REQ);
  assign ps2_data_drive_low = data_low & ~tmo;
  assign ack_ok             = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device model clocks the frame, a scoreboard holds expected frames and ACKs.
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_dl, data_dl, busy, done, ack_ok, error;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int total = 0, bad = 0, n_done = 0, n_err = 0;
  logic [9:0] frame_q[$];
  logic       ack_q[$];

  assign ps2_clk_in  = dev_clk & ~clk_dl;
  assign ps2_data_in = dev_data & ~data_dl;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(clk_dl), .ps2_data_drive_low(data_dl),
    .busy(busy), .done(done), .ack_ok(ack_ok), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  n_done++;
    if (error) n_err++;
  end

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    // Rising-edge samples: 8 data bits LSB first, odd parity, stop.
    logic p;
    p = ($countones(d) % 2 == 0);
    return {1'b1, p, d};
  endfunction

  task automatic req(input logic [7:0] d, input bit ack, input bit hold);
    int k;
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 100) begin k++; @(negedge clk); end
    total++;
    if (!tx_ready) begin bad++; $display("FAIL accept: tx_ready=%b required 1", tx_ready); end
    frame_q.push_back(frame_of(d));
    ack_q.push_back(ack);
    @(posedge clk);
    @(negedge clk);
    if (hold) tx_data = 8'h55;
    else tx_valid = 1'b0;
  endtask

  task automatic check_inhibit();
    int k = 0;
    while (clk_dl && !data_dl && k < INH + 100) begin k++; @(negedge clk); end
    total++;
    if (k !== INH) begin bad++; $display("FAIL inhibit_len: got %0d required %0d", k, INH); end
    total++;
    if (!(clk_dl && data_dl)) begin bad++; $display("FAIL req_cycle: clk_dl=%b data_dl=%b required 1 1", clk_dl, data_dl); end
    @(negedge clk);
    total++;
    if (clk_dl !== 1'b0 || data_dl !== 1'b1) begin
      bad++; $display("FAIL xfer_start: clk_dl=%b data_dl=%b required 0 1", clk_dl, data_dl);
    end
  endtask

  task automatic device(input bit ack, input int abort_fe, input bit glitch, output logic [9:0] bits);
    bits = '0;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (i == abort_fe) begin repeat (4) @(negedge clk); return; end
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = ps2_data_in;
      if (i == 11) begin dev_data = 1'b1; return; end
      if (glitch && i == 3) begin
        repeat (8) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    int e0 = n_err;
    logic exp_ack;
    while (!done && k < 200) begin k++; @(negedge clk); end
    exp_ack = ack_q.pop_front();
    total++;
    if (!done) begin bad++; $display("FAIL %s done: not seen within 200 cycles", name); end
    total++;
    if (ack_ok !== exp_ack) begin bad++; $display("FAIL %s ack_ok: got %b required %b", name, ack_ok, exp_ack); end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || n_err != e0) begin
      bad++; $display("FAIL %s after_done: tx_ready=%b errors=%0d required 1 %0d", name, tx_ready, n_err, e0);
    end
  endtask

  task automatic run_dev(input string name, input bit ack, input bit glitch);
    logic [9:0] bits, exp;
    device(ack, 0, glitch, bits);
    exp = frame_q.pop_front();
    total++;
    if (bits !== exp) begin bad++; $display("FAIL %s frame: got %b required %b", name, bits, exp); end
  endtask

  task automatic xfer(input logic [7:0] d, input bit ack, input string name);
    req(d, ack, 1'b0);
    check_inhibit();
    run_dev(name, ack, 1'b0);
    wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_ready, busy, done, error, ack_ok, clk_dl, data_dl} !== 7'b1000000) begin
      bad++; $display("FAIL reset_state: got %b required 1000000", {tx_ready, busy, done, error, ack_ok, clk_dl, data_dl});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_send();
    int d0 = n_done;
    xfer(8'hED, 1'b1, "send_ed");
    xfer(8'h07, 1'b1, "send_07");
    xfer(8'h00, 1'b1, "send_00");
    total++;
    if (n_done != d0 + 3 || n_err != 0) begin
      bad++; $display("FAIL send_counts: done=%0d err=%0d required %0d 0", n_done - d0, n_err, 3);
    end
  endtask

  task automatic test_nack();
    xfer(8'hF4, 1'b0, "nack");
  endtask

  task automatic test_timeout();
    int k = 0;
    int d0 = n_done;
    int e0 = n_err;
    req(8'hFF, 1'b0, 1'b0);
    check_inhibit();
    while (!error && k < TMO + 100) begin k++; @(negedge clk); end
    total++;
    if (k !== TMO) begin bad++; $display("FAIL timeout_time: got %0d required %0d", k, TMO); end
    total++;
    if (clk_dl !== 1'b0 || data_dl !== 1'b0) begin
      bad++; $display("FAIL timeout_lines: clk_dl=%b data_dl=%b required 0 0", clk_dl, data_dl);
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || ack_ok !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL timeout_after: tx_ready=%b ack_ok=%b error=%b required 1 0 0", tx_ready, ack_ok, error);
    end
    repeat (20) @(negedge clk);
    total++;
    if (n_done != d0 || n_err != e0 + 1) begin
      bad++; $display("FAIL timeout_pulses: done=%0d err=%0d required 0 1", n_done - d0, n_err - e0);
    end
    frame_q.delete();
    ack_q.delete();
  endtask

  task automatic test_back_to_back();
    req(8'hED, 1'b1, 1'b1);
    check_inhibit();
    run_dev("b2b_ed", 1'b1, 1'b0);
    wait_done("b2b_ed");
    frame_q.push_back(frame_of(8'h55));
    ack_q.push_back(1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    check_inhibit();
    run_dev("b2b_55", 1'b1, 1'b0);
    wait_done("b2b_55");
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    int d0 = n_done;
    int e0 = n_err;
    req(8'hA5, 1'b1, 1'b0);
    check_inhibit();
    device(1'b1, 4, 1'b0, bits);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({clk_dl, data_dl, busy, tx_ready} !== 4'b0001) begin
      bad++; $display("FAIL reset_mid: clk_dl,data_dl,busy,tx_ready=%b required 0001", {clk_dl, data_dl, busy, tx_ready});
    end
    dev_clk = 1'b1;
    repeat (50) @(negedge clk);
    total++;
    if (n_done != d0 || n_err != e0) begin
      bad++; $display("FAIL reset_mid_pulses: done=%0d err=%0d required 0 0", n_done - d0, n_err - e0);
    end
    frame_q.delete();
    ack_q.delete();
    xfer(8'hF4, 1'b1, "after_reset");
  endtask

`ifdef PS2_TX_GLITCH_FILTER_EN
  task automatic test_glitch();
    req(8'h3C, 1'b1, 1'b0);
    check_inhibit();
    run_dev("glitch", 1'b1, 1'b1);
    wait_done("glitch");
  endtask
`endif

  initial begin
    test_reset();
    test_send();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef PS2_TX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
